// File: rtl/dc_frame_packer.sv
// dc_frame_packer: transmit end of the DC/launch word-stream protocol.
// Serialises DC-register frames (header + FRAME_WORDS payload words) and
// launch commands (0xFFFF_FFFF marker + 4 command words) into a 32-bit FIFO.
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_frame_valid/o_frame_ready       frame handshake; i_frame_ch, i_frame_words payload
//   i_launch_valid/o_launch_ready     launch handshake; i_launch_cmd payload
//   o_fifo_wdata/o_fifo_wr/i_fifo_full  FIFO write side
//   o_frame_done, o_launch_done       1-cycle completion pulses
//   o_err_bad_ch                      1-cycle pulse, frame dropped for illegal channel
//   o_busy                            a transaction is in progress
module dc_frame_packer #(
    parameter int unsigned DAC_CHANNEL = 24,
    parameter int unsigned FRAME_WORDS = 62
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_valid,
    output logic                      o_frame_ready,
    input  logic [4:0]                i_frame_ch,
    input  logic [FRAME_WORDS*32-1:0] i_frame_words,
    input  logic                      i_launch_valid,
    output logic                      o_launch_ready,
    input  logic [4*32-1:0]           i_launch_cmd,
    output logic [31:0]               o_fifo_wdata,
    output logic                      o_fifo_wr,
    input  logic                      i_fifo_full,
    output logic                      o_frame_done,
    output logic                      o_launch_done,
    output logic                      o_err_bad_ch,
    output logic                      o_busy
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned CMD_WORDS = 4;
    localparam int unsigned PAY_W     = FRAME_WORDS * WORD_W;
    localparam int unsigned CMD_W     = CMD_WORDS * WORD_W;
    localparam int unsigned CNT_LOG   = $clog2(FRAME_WORDS);
    localparam int unsigned CNT_W     = (CNT_LOG > 2) ? CNT_LOG : 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_PAYLOAD,
        ST_SEND_MARK,
        ST_SEND_LAUNCH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PAY_W-1:0]   r_payload;
    logic [CMD_W-1:0]   r_cmd;
    logic [4:0]         r_ch;
    logic [7:0]         r_seq;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_done;
    logic               r_launch_done;
    logic               r_err_bad_ch;

    logic               w_idle;
    logic               w_wr;
    logic               w_ch_ok;
    logic               w_launch_acc;
    logic               w_frame_acc;
    logic               w_last_pay;
    logic               w_last_cmd;
    logic [31:0]        w_wdata;

    // Handshake and write qualification; launch has priority over a pending frame.
    assign w_idle       = (r_state == ST_IDLE);
    assign w_wr         = !w_idle && !i_fifo_full;
    assign w_ch_ok      = (32'(i_frame_ch) < DAC_CHANNEL);
    assign w_launch_acc = w_idle && i_launch_valid;
    assign w_frame_acc  = w_idle && i_frame_valid && !i_launch_valid;
    assign w_last_pay   = (r_cnt == CNT_W'(FRAME_WORDS - 1));
    assign w_last_cmd   = (r_cnt == CNT_W'(CMD_WORDS - 1));

    assign o_launch_ready = w_idle;
    assign o_frame_ready  = w_idle && !i_launch_valid;
    assign o_fifo_wr      = w_wr;
    assign o_fifo_wdata   = w_wdata;
    assign o_busy         = !w_idle;
    assign o_frame_done   = r_frame_done;
    assign o_launch_done  = r_launch_done;
    assign o_err_bad_ch   = r_err_bad_ch;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; every send state only advances on an actual FIFO write.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch_acc) begin
                    w_state_nxt = ST_SEND_MARK;
                end else if (w_frame_acc && w_ch_ok) begin
                    w_state_nxt = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR:     if (w_wr) w_state_nxt = ST_SEND_PAYLOAD;
            ST_SEND_PAYLOAD: if (w_wr && w_last_pay) w_state_nxt = ST_IDLE;
            ST_SEND_MARK:    if (w_wr) w_state_nxt = ST_SEND_LAUNCH;
            ST_SEND_LAUNCH:  if (w_wr && w_last_cmd) w_state_nxt = ST_IDLE;
            default:         w_state_nxt = ST_IDLE;
        endcase
    end

    // Write data mux; buffers shift down so word [0] is always the next to send.
    always_comb begin
        w_wdata = 32'h0;
        case (r_state)
            ST_SEND_HDR:     w_wdata = {~(24'd1 << r_ch), r_seq};
            ST_SEND_PAYLOAD: w_wdata = r_payload[WORD_W-1:0];
            ST_SEND_MARK:    w_wdata = 32'hFFFF_FFFF;
            ST_SEND_LAUNCH:  w_wdata = r_cmd[WORD_W-1:0];
            default:         w_wdata = 32'h0;
        endcase
    end

    // Capture buffers, word counter, sequence number and completion pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_payload     <= '0;
            r_cmd         <= '0;
            r_ch          <= 5'd0;
            r_seq         <= 8'd0;
            r_cnt         <= '0;
            r_frame_done  <= 1'b0;
            r_launch_done <= 1'b0;
            r_err_bad_ch  <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_launch_done <= 1'b0;
            r_err_bad_ch  <= 1'b0;

            if (w_frame_acc) begin
                if (w_ch_ok) begin
                    r_payload <= i_frame_words;
                    r_ch      <= i_frame_ch;
                end else begin
                    r_err_bad_ch <= 1'b1;
                end
            end
            if (w_launch_acc) begin
                r_cmd <= i_launch_cmd;
            end

            if (w_wr && (r_state == ST_SEND_PAYLOAD)) begin
                r_payload <= r_payload >> WORD_W;
                if (w_last_pay) begin
                    r_cnt        <= '0;
                    r_frame_done <= 1'b1;
                    r_seq        <= r_seq + 8'd1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_wr && (r_state == ST_SEND_LAUNCH)) begin
                r_cmd <= r_cmd >> WORD_W;
                if (w_last_cmd) begin
                    r_cnt         <= '0;
                    r_launch_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dc_frame_packer.sv
// tb_dc_frame_packer: directed self-checking bench for dc_frame_packer.
module tb_dc_frame_packer;

    localparam int unsigned FRAME_WORDS = 62;
    localparam int unsigned DAC_CHANNEL = 24;

    logic                      i_clk = 1'b0;
    logic                      i_rst = 1'b1;
    logic                      i_frame_valid = 1'b0;
    logic                      o_frame_ready;
    logic [4:0]                i_frame_ch = 5'd0;
    logic [FRAME_WORDS*32-1:0] i_frame_words = '0;
    logic                      i_launch_valid = 1'b0;
    logic                      o_launch_ready;
    logic [127:0]              i_launch_cmd = '0;
    logic [31:0]               o_fifo_wdata;
    logic                      o_fifo_wr;
    logic                      i_fifo_full = 1'b0;
    logic                      o_frame_done;
    logic                      o_launch_done;
    logic                      o_err_bad_ch;
    logic                      o_busy;

    dc_frame_packer #(.DAC_CHANNEL(DAC_CHANNEL), .FRAME_WORDS(FRAME_WORDS)) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_frame_valid  (i_frame_valid),
        .o_frame_ready  (o_frame_ready),
        .i_frame_ch     (i_frame_ch),
        .i_frame_words  (i_frame_words),
        .i_launch_valid (i_launch_valid),
        .o_launch_ready (o_launch_ready),
        .i_launch_cmd   (i_launch_cmd),
        .o_fifo_wdata   (o_fifo_wdata),
        .o_fifo_wr      (o_fifo_wr),
        .i_fifo_full    (i_fifo_full),
        .o_frame_done   (o_frame_done),
        .o_launch_done  (o_launch_done),
        .o_err_bad_ch   (o_err_bad_ch),
        .o_busy         (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_fdone = 0;
    int          n_ldone = 0;
    int          n_err = 0;
    int          fdone_cyc = 0;
    int          ldone_cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] wq[$];
    int          wc[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // FIFO-side monitor: a write seen here commits on the following rising edge.
    always @(negedge i_clk) begin
        if (o_fifo_wr) begin
            wq.push_back(o_fifo_wdata);
            wc.push_back(cyc);
        end
        if (o_frame_done)  begin n_fdone++; fdone_cyc = cyc; end
        if (o_launch_done) begin n_ldone++; ldone_cyc = cyc; end
        if (o_err_bad_ch)  n_err++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr(input int ch, input int seq);
        logic [23:0] one;
        one = 24'd1;
        return {~(one << ch), 8'(seq)};
    endfunction

    function automatic logic [31:0] pay(input logic [15:0] tag, input int i);
        return {tag, 16'(i + 1)};
    endfunction

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_log();
        wq.delete();
        wc.delete();
    endtask

    task automatic fill_payload(input logic [15:0] tag);
        for (int i = 0; i < int'(FRAME_WORDS); i++) i_frame_words[i*32 +: 32] = pay(tag, i);
    endtask

    task automatic do_frame(input int ch);
        logic rdy;
        i_frame_ch    = 5'(ch);
        i_frame_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk) rdy = o_frame_ready;
            @(posedge i_clk);
            if (rdy) break;
        end
        #1;
        acc_cyc       = cyc;
        i_frame_valid = 1'b0;
    endtask

    task automatic do_launch();
        logic rdy;
        i_launch_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge i_clk) rdy = o_launch_ready;
            @(posedge i_clk);
            if (rdy) break;
        end
        #1;
        i_launch_valid = 1'b0;
    endtask

    task automatic wait_fdone(input int target);
        for (int k = 0; k < 400 && n_fdone < target; k++) @(posedge i_clk);
        @(posedge i_clk); #1;
        chk("frame_done_count", 32'(n_fdone), 32'(target));
    endtask

    task automatic wait_ldone(input int target);
        for (int k = 0; k < 400 && n_ldone < target; k++) @(posedge i_clk);
        @(posedge i_clk); #1;
        chk("launch_done_count", 32'(n_ldone), 32'(target));
    endtask

    task automatic check_frame(input string tag, input int base, input int ch,
                               input int seq, input logic [15:0] ptag);
        chk({tag, "_hdr"}, wq_at(base), hdr(ch, seq));
        for (int i = 0; i < int'(FRAME_WORDS); i++)
            chk({tag, "_pay"}, wq_at(base + 1 + i), pay(ptag, i));
    endtask

    initial begin
        int n_before;
        int f_before;

        // Reset state.
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_busy",    32'(o_busy), 32'd0);
        chk("rst_wr",      32'(o_fifo_wr), 32'd0);
        chk("rst_wdata",   o_fifo_wdata, 32'h0);
        chk("rst_pulses",  32'({o_frame_done, o_launch_done, o_err_bad_ch}), 32'd0);
        chk("rst_ready",   32'({o_frame_ready, o_launch_ready}), 32'd3);

        // Single frame, ch=5, payload i+1, FIFO never full.
        @(posedge i_clk); #1;
        clear_log();
        fill_payload(16'h0000);
        do_frame(5);
        wait_fdone(1);
        chk("f1_count", 32'(wq.size()), 32'd63);
        chk("f1_hdr_literal", wq_at(0), 32'hFFFF_DF00);
        check_frame("f1", 0, 5, 0, 16'h0000);
        if (wc.size() == 63) begin
            chk("f1_first_latency", 32'(wc[0]), 32'(acc_cyc));
            chk("f1_contiguous",    32'(wc[62] - wc[0]), 32'd62);
            chk("f1_done_timing",   32'(fdone_cyc), 32'(wc[62] + 1));
        end

        // Launch.
        clear_log();
        i_launch_cmd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        do_launch();
        wait_ldone(1);
        chk("l1_count", 32'(wq.size()), 32'd5);
        chk("l1_mark",  wq_at(0), 32'hFFFF_FFFF);
        chk("l1_a",     wq_at(1), 32'hAAAA_0001);
        chk("l1_b",     wq_at(2), 32'hBBBB_0002);
        chk("l1_c",     wq_at(3), 32'hCCCC_0003);
        chk("l1_d",     wq_at(4), 32'hDDDD_0004);
        if (wc.size() == 5) begin
            chk("l1_contiguous", 32'(wc[4] - wc[0]), 32'd4);
            chk("l1_done_timing", 32'(ldone_cyc), 32'(wc[4] + 1));
        end

        // Back-pressure for 3 cycles on payload word 10; one payload word is a marker value.
        clear_log();
        fill_payload(16'h0B00);
        i_frame_words[5*32 +: 32] = 32'hFFFF_FFFF;
        do_frame(3);
        for (int k = 0; k < 200 && wq.size() < 11; k++) begin @(posedge i_clk); #1; end
        i_fifo_full = 1'b1;
        n_before = wq.size();
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("bp_no_wr", 32'(o_fifo_wr), 32'd0);
            chk("bp_held_word", o_fifo_wdata, pay(16'h0B00, 10));
        end
        @(posedge i_clk); #1;
        i_fifo_full = 1'b0;
        chk("bp_no_log_while_full", 32'(wq.size()), 32'(n_before));
        wait_fdone(2);
        chk("bp_count", 32'(wq.size()), 32'd63);
        chk("bp_hdr", wq_at(0), hdr(3, 1));
        for (int i = 0; i < int'(FRAME_WORDS); i++)
            chk("bp_pay", wq_at(1 + i),
                (i == 5) ? 32'hFFFF_FFFF : pay(16'h0B00, i));

        // Bad channels 24 and 31: consumed, nothing written.
        clear_log();
        do_frame(24);
        @(negedge i_clk);
        chk("bad24_busy", 32'(o_busy), 32'd0);
        repeat (4) @(posedge i_clk);
        #1;
        chk("bad24_err", 32'(n_err), 32'd1);
        do_frame(31);
        repeat (5) @(posedge i_clk);
        #1;
        chk("bad31_err", 32'(n_err), 32'd2);
        chk("bad_writes", 32'(wq.size()), 32'd0);
        chk("bad_no_done", 32'(n_fdone), 32'd2);

        // Simultaneous launch and frame ch=0: launch first, frame follows, seq still 2.
        clear_log();
        fill_payload(16'h5500);
        i_launch_cmd = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        i_frame_ch     = 5'd0;
        i_frame_valid  = 1'b1;
        i_launch_valid = 1'b1;
        #1;
        chk("sim_frame_ready", 32'(o_frame_ready), 32'd0);
        chk("sim_launch_ready", 32'(o_launch_ready), 32'd1);
        fork
            do_launch();
            do_frame(0);
        join
        wait_fdone(3);
        chk("sim_count", 32'(wq.size()), 32'd68);
        chk("sim_mark", wq_at(0), 32'hFFFF_FFFF);
        chk("sim_cmd0", wq_at(1), 32'h1111_1111);
        chk("sim_cmd3", wq_at(4), 32'h4444_4444);
        chk("sim_hdr_literal", wq_at(5), 32'hFFFF_FE02);
        check_frame("sim", 5, 0, 2, 16'h5500);

        // Sequence wrap: frames 4..256 carry seq 3..255, frame 257 carries 0.
        for (int k = 4; k <= 256; k++) begin
            clear_log();
            do_frame(k % int'(DAC_CHANNEL));
            wait_fdone(k);
            chk("wrap_hdr", wq_at(0), hdr(k % int'(DAC_CHANNEL), k - 1));
        end
        clear_log();
        fill_payload(16'h7700);
        f_before = n_fdone;
        do_frame(7);
        for (int k = 0; k < 200 && wq.size() < 21; k++) begin @(posedge i_clk); #1; end
        chk("wrap257_hdr", wq_at(0), 32'hFFFF_7F00);
        chk("wrap257_pay19", wq_at(20), pay(16'h7700, 19));
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_wr",    32'(o_fifo_wr), 32'd0);
        chk("midrst_busy",  32'(o_busy), 32'd0);
        chk("midrst_wdata", o_fifo_wdata, 32'h0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("midrst_no_done", 32'(n_fdone), 32'(f_before));

        // Sequence counter restarts at 0 after reset.
        clear_log();
        fill_payload(16'h0900);
        do_frame(2);
        wait_fdone(f_before + 1);
        chk("post_rst_count", 32'(wq.size()), 32'd63);
        check_frame("post_rst", 0, 2, 0, 16'h0900);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
